// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Synchronous FIFO that buffers ALU results with their opcode,
//               using valid/ready handshakes on both sides.
//               Define ALU_RESULT_FIFO_FLAGS_EN to add per-entry zero/parity
//               flags (out_zero, out_parity).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_result,
    input  logic [1:0]              in_operation,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic [1:0]              out_operation,
`ifdef ALU_RESULT_FIFO_FLAGS_EN
    output logic                    out_zero,
    output logic                    out_parity,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem_result [DEPTH];
    logic [1:0]            r_mem_op     [DEPTH];
`ifdef ALU_RESULT_FIFO_FLAGS_EN
    logic                  r_mem_zero   [DEPTH];
    logic                  r_mem_parity [DEPTH];
`endif

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Handshake readiness depends only on the occupancy register.
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    assign out_result    = r_mem_result[r_rd_ptr];
    assign out_operation = r_mem_op[r_rd_ptr];
`ifdef ALU_RESULT_FIFO_FLAGS_EN
    assign out_zero      = r_mem_zero[r_rd_ptr];
    assign out_parity    = r_mem_parity[r_rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_push) begin
            r_mem_result[r_wr_ptr] <= in_result;
            r_mem_op[r_wr_ptr]     <= in_operation;
`ifdef ALU_RESULT_FIFO_FLAGS_EN
            r_mem_zero[r_wr_ptr]   <= (in_result == '0);
            r_mem_parity[r_wr_ptr] <= ^in_result;
`endif
        end
    end

endmodule
`default_nettype wire
